// File: rtl/microc_call_stack.sv
// microc_call_stack: single-cycle 8-bit microcontroller datapath with a
// 16x8 register file, ALU, zero flag, 10-bit PC and a hardware return-address
// stack for call/return. Overflow and underflow of the stack are recorded in
// sticky flags that only reset clears.
module microc_call_stack #(
   parameter int         SDEPTH  = 4,
   parameter logic [9:0] RST_VEC = 10'h000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [15:0]             instr,
   output logic [9:0]              pc,
   output logic [5:0]              opcode,
   output logic                    z,
   input  logic                    s_inc,
   input  logic                    s_inm,
   input  logic                    we3,
   input  logic                    wez,
   input  logic [2:0]              op,
   input  logic                    push,
   input  logic                    pop,
   output logic [$clog2(SDEPTH):0] sp,
   output logic                    stk_ovf,
   output logic                    stk_unf
);

   localparam int AW  = $clog2(SDEPTH);
   localparam int SPW = AW + 1;
   localparam logic [SPW-1:0] SP_FULL = SPW'(SDEPTH);

   typedef enum logic [2:0] {
      ALU_A    = 3'b000,
      ALU_NOTA = 3'b001,
      ALU_ADD  = 3'b010,
      ALU_SUB  = 3'b011,
      ALU_AND  = 3'b100,
      ALU_OR   = 3'b101,
      ALU_NEGA = 3'b110,
      ALU_NEGB = 3'b111
   } alu_op_e;

   logic [7:0]     rf    [16];
   logic [9:0]     stack [SDEPTH];

   logic [3:0]     ra1, ra2, wa3;
   logic [7:0]     rd1, rd2, alu_y, wd3;
   logic           alu_zero;
   logic [9:0]     pc_inc, pc_next, stk_top;
   logic [SPW-1:0] sp_dec;
   logic [AW-1:0]  top_idx, wr_idx;
   logic           stk_empty, stk_full;

   assign opcode = instr[15:10];
   assign ra1    = instr[11:8];
   assign ra2    = instr[7:4];
   assign wa3    = instr[3:0];

   // R0 is hardwired to zero regardless of what the array holds
   assign rd1 = (ra1 == 4'd0) ? 8'h00 : rf[ra1];
   assign rd2 = (ra2 == 4'd0) ? 8'h00 : rf[ra2];

   // 8-bit ALU; all results wrap mod 256
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      alu_y = 8'h00;
      case (alu_op_e'(op))
         ALU_A:    alu_y = rd1;
         ALU_NOTA: alu_y = ~rd1;
         ALU_ADD:  alu_y = rd1 + rd2;
         ALU_SUB:  alu_y = rd1 - rd2;
         ALU_AND:  alu_y = rd1 & rd2;
         ALU_OR:   alu_y = rd1 | rd2;
         ALU_NEGA: alu_y = 8'h00 - rd1;
         ALU_NEGB: alu_y = 8'h00 - rd2;
         default:  alu_y = 8'h00;
      endcase
   end

   assign alu_zero = (alu_y == 8'h00);
   assign wd3      = s_inm ? instr[11:4] : alu_y;

   // Stack bookkeeping: sp counts occupied entries, top is entry sp-1
   assign pc_inc    = pc + 10'd1;
   assign stk_empty = (sp == '0);
   assign stk_full  = (sp == SP_FULL);
   assign sp_dec    = sp - SPW'(1);
   assign top_idx   = sp_dec[AW-1:0];
   assign wr_idx    = sp[AW-1:0];
   assign stk_top   = stack[top_idx];

   // Next-PC priority: return, failed return, jump, increment
   always_comb begin
      pc_next = pc_inc;
      if (pop && !stk_empty)
         pc_next = stk_top;
      else if (pop)
         pc_next = pc_inc;
      else if (!s_inc)
         pc_next = instr[9:0];
   end

   // PC, zero flag, return stack, stack pointer and sticky flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= RST_VEC;
         z       <= 1'b0;
         sp      <= '0;
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
         // NOTE: the stack is cleared on reset because its contents are
         // architecturally defined as zero afterwards; this costs a reset
         // net on every entry, so only do it for small memories like this.
         for (int i = 0; i < SDEPTH; i++)
            stack[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         pc <= pc_next;
         if (wez)
            z <= alu_zero;
         if (pop) begin
            if (stk_empty)
               stk_unf <= 1'b1;
            else if (push)
               stack[top_idx] <= pc_inc;
            else
               sp <= sp_dec;
         end else if (push) begin
            if (stk_full) begin
               stk_ovf <= 1'b1;
            end else begin
               stack[wr_idx] <= pc_inc;
               sp            <= sp + SPW'(1);
            end
         end
      end
   end

   // Register file: writes to R0 are discarded
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++)
            rf[i] <= 8'h00;
      end else if (we3 && (wa3 != 4'd0)) begin
         rf[wa3] <= wd3;
      end
   end

endmodule
